// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// default memory depth and the request legality check.
package lsu_pkg;

   localparam int unsigned MEM_WORDS_DEFAULT = 4096;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

   // Illegal encoding, misalignment or an address beyond the memory depth.
   function automatic logic req_err(input logic        we,
                                    input logic [2:0]  funct3,
                                    input logic [31:0] addr,
                                    input int unsigned mem_words);
      logic illegal;
      logic misaligned;
      logic out_of_range;
      illegal      = we ? (funct3 > F3_W)
                        : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      misaligned   = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
      out_of_range = {2'b00, addr[31:2]} >= mem_words;
      return illegal | misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and the
// store merge of new lane(s) into the word read back from memory.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
      half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];
      unique case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_BU:   load_data_o = {24'h000000, byte_sel};
         F3_HU:   load_data_o = {16'h0000, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

   always_comb begin
      store_data_o = rdata_i;
      unique case (funct3_i)
         F3_B:    store_data_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
         F3_H:    store_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: store_data_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide Data_Memory: one request in
// flight, sub-word stores done as read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        mem_wr_en,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic        accept;
   logic [31:0] load_data;
   logic [31:0] store_data;

   assign accept = req_valid && (state_q == IDLE);

   lsu_align u_align (
      .funct3_i     (f3_q),
      .lane_i       (addr_q[1:0]),
      .rdata_i      (mem_rdata),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .store_data_o (store_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err(req_we, req_funct3, req_addr, MEM_WORDS);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err(req_we, req_funct3, req_addr, MEM_WORDS))
                  state_d = RESP;
               else if (req_we && req_funct3 == F3_W)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            mem_rd_en = 1'b1;
            mem_addr  = {2'b00, addr_q[31:2]};
            state_d   = we_q ? WR : RESP;
         end
         // mem_rdata here is the word fetched in RD; the merge only applies to SB/SH.
         WR: begin
            mem_wr_en = 1'b1;
            mem_addr  = {2'b00, addr_q[31:2]};
            mem_wdata = store_data;
            state_d   = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (!we_q && !err_q) ? load_data : '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
